// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, PC step and queue entry layout for the fetch stage
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] INST_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus and decode handshake
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic imem_req;
  logic imem_gnt;
  logic imem_rvalid;
  logic id_valid;
  logic id_ready;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] id_pc;
  logic [ILEN-1:0] imem_rdata;
  logic [ILEN-1:0] id_inst;
  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_inst,
    input imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
  modport slave (
    input imem_req, imem_addr, id_valid, id_pc, id_inst,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small circular FIFO with synchronous flush and occupancy count
module fetch_fifo #(
  parameter int W = 32,
  parameter int D = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(D+1)-1:0] cnt
);
  localparam int CW = $clog2(D + 1);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  logic [W-1:0] mem [D];
  logic [PW-1:0] rp, wp;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(D - 1) ? '0 : p + PW'(1);
  endfunction
  assign dout = mem[rp];
  // push into a full FIFO is only legal alongside a pop: wp == rp and the head is read before the write lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (flush) begin
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch around the PC register with a flushable decode queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] out_cnt, q_cnt, drop_cnt;
  logic [XLEN-1:0] fl_pc;
  fetch_entry_t head;
  logic pop, credit, fire, enq;
  assign pop = bus.id_valid & bus.id_ready;
  // outstanding requests plus queued entries never exceed DEPTH, so every response has a slot
  assign credit = ({1'b0, out_cnt} + {1'b0, q_cnt}) < ((CW+1)'(DEPTH) + (CW+1)'(pop));
  assign bus.imem_req = credit & ~redirect_valid & ~rst;
  assign bus.imem_addr = pc;
  assign fire = bus.imem_req & bus.imem_gnt;
  assign npc = redirect_valid ? redirect_pc : fire ? pc + INST_STEP : pc;
  assign enq = bus.imem_rvalid & (drop_cnt == '0);
  assign bus.id_valid = q_cnt != '0;
  assign bus.id_pc = head.pc;
  assign bus.id_inst = head.inst;
  fetch_fifo #(.W(XLEN), .D(DEPTH)) u_inflight (
    .clk, .rst, .flush(1'b0), .push(fire), .pop(bus.imem_rvalid),
    .din(pc), .dout(fl_pc), .cnt(out_cnt)
  );
  fetch_fifo #(.W($bits(fetch_entry_t)), .D(DEPTH)) u_queue (
    .clk, .rst, .flush(redirect_valid), .push(enq), .pop,
    .din({fl_pc, bus.imem_rdata}), .dout(head), .cnt(q_cnt)
  );
  // responses already in flight at a redirect belong to the old path and are discarded
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (redirect_valid) drop_cnt <= out_cnt - CW'(bus.imem_rvalid);
    else if (bus.imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a sequential-stream reference model and an in-order memory model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam int DEPTH = 2;
  logic clk, rst;
  logic [31:0] pc, npc, redirect_pc;
  logic redirect_valid;
  fetch_unit_if bus();
  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .npc(npc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} rsp_t;
  rsp_t mq[$];
  int total, bad, cyc, out_n, pops, lat_max, last_due;
  logic [31:0] pc_next, exp_pc, prev_pc, prev_inst, last_npc;
  logic prev_redir, prev_hold, last_fire;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  task automatic step(input logic g, input logic r, input logic rv, input logic [31:0] rp);
    logic [31:0] e_npc;
    logic fire, resp;
    int d;
    @(negedge clk);
    pc = pc_next;
    bus.imem_gnt = g;
    bus.id_ready = r;
    redirect_valid = rv;
    redirect_pc = rp;
    resp = mq.size() > 0 && mq[0].due <= cyc;
    bus.imem_rvalid = resp;
    bus.imem_rdata = resp ? inst_of(mq[0].addr) : $urandom;
    #1;
    fire = bus.imem_req & g;
    e_npc = rv ? rp : fire ? pc + 32'd4 : pc;
    total++;
    if (npc !== e_npc) begin bad++; $display("FAIL npc: got %h want %h (pc %h)", npc, e_npc, pc); end
    if (bus.imem_req) begin
      total++;
      if (bus.imem_addr !== pc) begin bad++; $display("FAIL imem_addr: got %h want %h", bus.imem_addr, pc); end
    end
    if (rv) begin
      total++;
      if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL req_on_redirect: got %b want 0", bus.imem_req); end
    end
    if (prev_redir) begin
      total++;
      if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL flush: id_valid got %b want 0", bus.id_valid); end
    end
    if (prev_hold && !prev_redir) begin
      total++;
      if ({bus.id_pc, bus.id_inst} !== {prev_pc, prev_inst}) begin
        bad++; $display("FAIL stable: got %h/%h want %h/%h", bus.id_pc, bus.id_inst, prev_pc, prev_inst);
      end
    end
    if (bus.id_valid === 1'b1 && r) begin
      pops++;
      total++;
      if (bus.id_pc !== exp_pc || bus.id_inst !== inst_of(exp_pc)) begin
        bad++; $display("FAIL order: got %h/%h want %h/%h", bus.id_pc, bus.id_inst, exp_pc, inst_of(exp_pc));
      end
      exp_pc += 32'd4;
    end
    if (rv) exp_pc = rp;
    if (fire) begin
      d = cyc + $urandom_range(1, lat_max);
      d = d > last_due ? d : last_due + 1;
      mq.push_back('{pc, d});
      last_due = d;
      out_n++;
    end
    if (resp) begin
      void'(mq.pop_front());
      out_n--;
    end
    total++;
    if (out_n > DEPTH) begin bad++; $display("FAIL outstanding: got %0d want <=%0d", out_n, DEPTH); end
    prev_redir = rv;
    prev_hold = bus.id_valid & ~r;
    prev_pc = bus.id_pc;
    prev_inst = bus.id_inst;
    last_fire = fire;
    last_npc = npc;
    pc_next = npc;
    cyc++;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.id_ready = 0;
    redirect_valid = 0;
    mq.delete();
    out_n = 0;
    last_due = cyc;
    pc = RESET_PC;
    pc_next = RESET_PC;
    exp_pc = RESET_PC;
    prev_redir = 0;
    prev_hold = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    #1;
    total += 4;
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.id_valid); end
    if (bus.id_pc !== 32'd0) begin bad++; $display("FAIL rst_pc: got %h want 0", bus.id_pc); end
    if (bus.id_inst !== 32'd0) begin bad++; $display("FAIL rst_inst: got %h want 0", bus.id_inst); end
  endtask
  task automatic test_stream;
    do_reset();
    lat_max = 1;
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 0, 0);
      total++;
      if (bus.id_valid !== (k >= 2)) begin bad++; $display("FAIL stream_valid k=%0d: got %b want %b", k, bus.id_valid, k >= 2); end
    end
  endtask
  task automatic test_stall;
    int f = 0;
    int p0;
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0, 0);
      f += int'(last_fire);
    end
    total += 2;
    if (f > 2) begin bad++; $display("FAIL stall_grants: got %0d want <=2", f); end
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", bus.imem_req); end
    p0 = pops;
    repeat (10) step(1, 1, 0, 0);
    total++;
    if (pops - p0 < 9) begin bad++; $display("FAIL stall_resume: got %0d pops want >=9", pops - p0); end
  endtask
  task automatic test_gnt_low;
    repeat (3) begin
      step(0, 1, 0, 0);
      total++;
      if (npc !== pc) begin bad++; $display("FAIL gnt_low_npc: got %h want %h", npc, pc); end
    end
    repeat (6) step(1, 1, 0, 0);
  endtask
  task automatic test_redirect;
    int p0;
    bit hit = 0;
    lat_max = 3;
    for (int k = 0; k < 20 && !hit; k++) begin
      step(1, 1, 0, 0);
      hit = out_n == 2;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL redirect_setup: outstanding got %0d want 2", out_n); end
    step(1, 1, 1, 32'h100);
    total++;
    if (last_npc !== 32'h100) begin bad++; $display("FAIL redirect_npc: got %h want 00000100", last_npc); end
    p0 = pops;
    repeat (15) step(1, 1, 0, 0);
    total++;
    if (pops == p0) begin bad++; $display("FAIL redirect_resume: got 0 pops want >0"); end
    lat_max = 1;
    repeat (4) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h200);
    repeat (8) step(1, 1, 0, 0);
  endtask
  task automatic test_wrap;
    bit hit = 0;
    step(1, 1, 1, 32'hFFFFFFFC);
    for (int k = 0; k < 10 && !hit; k++) begin
      step(1, 1, 0, 0);
      hit = last_fire && pc == 32'hFFFFFFFC;
    end
    total += 2;
    if (!hit) begin bad++; $display("FAIL wrap_grant: no grant at ffffffc within 10 cycles"); end
    if (last_npc !== 32'd0) begin bad++; $display("FAIL wrap_npc: got %h want 0", last_npc); end
    repeat (6) step(1, 1, 0, 0);
  endtask
  task automatic test_random;
    int p0 = pops;
    lat_max = 3;
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom & 32'hFFFFFFFC);
    total++;
    if (pops - p0 < 50) begin bad++; $display("FAIL random_progress: got %0d pops want >=50", pops - p0); end
  endtask
  task automatic test_midreset;
    lat_max = 1;
    repeat (6) step(1, 1, 0, 0);
    @(negedge clk);
    #3;
    rst = 1;
    #1;
    total += 2;
    if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", bus.id_valid); end
    if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req: got %b want 0", bus.imem_req); end
    test_stream();
  endtask
  initial begin
    rst = 1;
    pc = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    bus.imem_gnt = 0;
    bus.imem_rvalid = 0;
    bus.imem_rdata = 0;
    bus.id_ready = 0;
    total = 0;
    bad = 0;
    cyc = 0;
    pops = 0;
    lat_max = 1;
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_redirect();
    test_wrap();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
